// File: rtl/dac_phase_ctrl.sv
// Control stage ahead of the AD9763 waveform table. It synchronises and debounces the
// active-low select switches, drives the LEDs, and runs the phase accumulator.
module dac_phase_ctrl #(
    parameter int unsigned        DEB_CYCLES  = 50000,
    parameter int unsigned        PHASE_W     = 24,
    parameter int unsigned        ADDR_W      = 5,
    parameter logic [PHASE_W-1:0] FTW_DEFAULT = PHASE_W'(1) << (PHASE_W - ADDR_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         sel_n,
    input  logic [PHASE_W-1:0] ftw,
    input  logic               ftw_load,
    output logic [ADDR_W-1:0]  addr,
    output logic [1:0]         wave_sel,
    output logic               wrap,
    output logic [3:0]         LED
);

    localparam int unsigned      CNT_W    = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYCLES - 1);
    localparam logic [3:0]       SW_IDLE  = 4'b1111;
    localparam logic [1:0]       REQ_DEF  = 2'd3;

    logic [3:0]         sync1_q, sync1_d;
    logic [3:0]         sync2_q, sync2_d;
    logic [3:0]         cand_q, cand_d;
    logic [3:0]         stable_q, stable_d;
    logic [3:0]         led_q, led_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic [PHASE_W-1:0] ftw_q, ftw_d;
    logic [1:0]         wave_q, wave_d;
    logic               wrap_q, wrap_d;

    logic [1:0]         req_c;
    logic [PHASE_W-1:0] sum_c;
    logic               carry_c;

    // Exact one-hot-low decode; anything else (none or several pressed) selects fsine
    always_comb begin
        req_c = REQ_DEF;
        case (stable_q)
            4'b1110: req_c = 2'd0;
            4'b1101: req_c = 2'd1;
            4'b1011: req_c = 2'd2;
            default: req_c = REQ_DEF;
        endcase
    end

    always_comb begin
        {carry_c, sum_c} = {1'b0, phase_q} + {1'b0, ftw_q};
    end

    always_comb begin
        sync1_d  = sel_n;
        sync2_d  = sync1_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        led_d    = 4'b1111 & ~(4'b0001 << req_c);
        phase_d  = sum_c;
        wrap_d   = carry_c;
        wave_d   = wave_q;
        ftw_d    = ftw_q;

        // Whole-vector debounce: any difference restarts the count
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_TERM) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            stable_d = cand_q;
        end

        // Switch only at a wrap, or continuously when the accumulator is frozen
        if (carry_c || (ftw_q == '0)) begin
            wave_d = req_c;
        end

        if (ftw_load) begin
            ftw_d = ftw;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q  <= SW_IDLE;
            sync2_q  <= SW_IDLE;
            cand_q   <= SW_IDLE;
            stable_q <= SW_IDLE;
            cnt_q    <= '0;
            led_q    <= 4'b0111;
            phase_q  <= '0;
            ftw_q    <= FTW_DEFAULT;
            wave_q   <= REQ_DEF;
            wrap_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            led_q    <= led_d;
            phase_q  <= phase_d;
            ftw_q    <= ftw_d;
            wave_q   <= wave_d;
            wrap_q   <= wrap_d;
        end
    end

    assign addr     = phase_q[PHASE_W-1 -: ADDR_W];
    assign wave_sel = wave_q;
    assign wrap     = wrap_q;
    assign LED      = led_q;

endmodule
